// File: rtl/att_agc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : att_agc_if                                              |
// | Function : Control, sample and status bundle of the AGC stage      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface att_agc_if #(
  parameter int PW = 16
) ();
  logic          agc_en;
  logic [5:0]    man_setting;
  logic          peak_valid;
  logic [PW-1:0] peak;
  logic [PW-1:0] thr_hi;
  logic [PW-1:0] thr_lo;
  logic [5:0]    setting;
  logic          changed;
  logic          ovr;
  logic [7:0]    ovr_cnt;
  logic [1:0]    state_o;

  // Side that supplies samples and thresholds and reads back status
  modport master (
    output agc_en, man_setting, peak_valid, peak, thr_hi, thr_lo,
    input  setting, changed, ovr, ovr_cnt, state_o
  );

  // The AGC stage itself
  modport slave (
    input  agc_en, man_setting, peak_valid, peak, thr_hi, thr_lo,
    output setting, changed, ovr, ovr_cnt, state_o
  );
endinterface
`default_nettype wire

// File: rtl/att_agc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : att_agc                                                 |
// | Function : Threshold-stepped attenuation control with hysteresis,  |
// |            settle holdoff, overload counting and manual bypass     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module att_agc #(
  parameter int PW      = 16,
  parameter int STEP    = 1,
  parameter int HOLDOFF = 32,
  parameter int CONSEC  = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  att_agc_if.slave bus
);

  localparam int            HW        = $clog2(HOLDOFF);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF - 1);
  localparam logic [3:0]    CONSEC_C  = 4'(CONSEC);
  localparam logic [6:0]    STEP_C    = 7'(STEP);
  localparam logic [5:0]    SET_MAX   = 6'd63;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_TRACK  = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    setting_q, setting_d;
  logic          changed_q, changed_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    ovr_cnt_q, ovr_cnt_d;
  logic [3:0]    low_cnt_q, low_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // 7-bit step arithmetic so the clamps see the carry/borrow instead of a wrap
  logic [6:0] sum7, diff7;
  logic [5:0] setting_up, setting_dn;
  logic       peak_hi, peak_lo;
  logic [3:0] low_inc;

  assign sum7       = {1'b0, setting_q} + STEP_C;
  assign diff7      = {1'b0, setting_q} - STEP_C;
  assign setting_up = sum7[6]  ? SET_MAX : sum7[5:0];
  assign setting_dn = diff7[6] ? 6'd0    : diff7[5:0];
  assign peak_hi    = bus.peak > bus.thr_hi;
  assign peak_lo    = bus.peak < bus.thr_lo;
  assign low_inc    = low_cnt_q + 4'd1;

  // Next-state, next-setting and status computation
  always_comb begin
    state_d    = state_q;
    setting_d  = setting_q;
    low_cnt_d  = low_cnt_q;
    hold_cnt_d = hold_cnt_q;
    ovr_d      = 1'b0;
    ovr_cnt_d  = ovr_cnt_q;

    if (!bus.agc_en) begin
      state_d    = ST_MANUAL;
      low_cnt_d  = 4'd0;
      hold_cnt_d = '0;
      // Manual code is only applied once the FSM actually sits in MANUAL
      if (state_q == ST_MANUAL) setting_d = bus.man_setting;
    end else begin
      case (state_q)
        ST_MANUAL: state_d = ST_TRACK;  // keep current setting, no jump
        ST_TRACK: begin
          if (bus.peak_valid) begin
            // Overload wins over underload when thresholds are crossed
            if (peak_hi) begin
              setting_d = setting_up;
              low_cnt_d = 4'd0;
              if (setting_q == SET_MAX) begin
                ovr_d = 1'b1;
                if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
              end
            end else if (peak_lo) begin
              if (low_inc == CONSEC_C) begin
                setting_d = setting_dn;
                low_cnt_d = 4'd0;
              end else begin
                low_cnt_d = low_inc;
              end
            end else begin
              low_cnt_d = 4'd0;
            end
            // A clamped step that leaves the code unchanged needs no settling
            if (setting_d != setting_q) begin
              state_d    = ST_HOLD;
              hold_cnt_d = HOLD_INIT;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == '0) state_d = ST_TRACK;
          else                  hold_cnt_d = hold_cnt_q - 1'b1;
        end
        default: begin
          state_d    = ST_MANUAL;
          low_cnt_d  = 4'd0;
          hold_cnt_d = '0;
        end
      endcase
    end

    changed_d = (setting_d != setting_q);
  end

  // State and registered outputs; reset parks at maximum attenuation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_MANUAL;
      setting_q  <= SET_MAX;
      changed_q  <= 1'b0;
      ovr_q      <= 1'b0;
      ovr_cnt_q  <= 8'd0;
      low_cnt_q  <= 4'd0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      setting_q  <= setting_d;
      changed_q  <= changed_d;
      ovr_q      <= ovr_d;
      ovr_cnt_q  <= ovr_cnt_d;
      low_cnt_q  <= low_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.setting = setting_q;
  assign bus.changed = changed_q;
  assign bus.ovr     = ovr_q;
  assign bus.ovr_cnt = ovr_cnt_q;
  assign bus.state_o = state_q;

endmodule
`default_nettype wire
